// File: rtl/io_port_bank_if.sv
// rtl/io_port_bank_if.sv - access bus and completion outputs of the io_port_bank register file
interface io_port_bank_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0]   io_addr;
    logic                io_en;
    logic                io_we;
    logic [DATA_W/8-1:0] io_be;
    logic [DATA_W-1:0]   io_data_write;
    logic [DATA_W-1:0]   io_data_read;
    logic                io_rvalid;
    logic                io_err;
    logic                tohost_done;
    logic [DATA_W-1:0]   tohost_code;

    modport master (
        output io_addr, io_en, io_we, io_be, io_data_write,
        input  io_data_read, io_rvalid, io_err, tohost_done, tohost_code
    );

    modport slave (
        input  io_addr, io_en, io_we, io_be, io_data_write,
        output io_data_read, io_rvalid, io_err, tohost_done, tohost_code
    );
endinterface

// File: rtl/io_port_bank.sv
// rtl/io_port_bank.sv - byte-enabled register bank with pipelined reads; IO_PORT_BANK_TOHOST_EN adds the test-completion register
module io_port_bank #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 10,
    parameter int RD_LAT     = 1,
    parameter int INIT_BASE  = 4096,
    parameter int TOHOST_IDX = DEPTH - 1
) (
    input  logic          clk,
    input  logic          reset,
    io_port_bank_if.slave bus
);
    localparam int BE_W   = DATA_W / 8;
    localparam int OFF_W  = (BE_W > 1) ? $clog2(BE_W) : 0;
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S2   = 2'd2
    } pipe_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic [MEM_AW-1:0] mem_idx;
    logic              in_range;
    logic              rd_fire;
    logic              wr_fire;
    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rd_data;

    pipe_state_t       st1, st1_next;
    pipe_state_t       st2, st2_next;
    logic [DATA_W-1:0] s1_data;
    logic              s1_err;
    logic [DATA_W-1:0] out_data;
    logic              out_err;
    logic              wr_err_q;
    logic              load_out;
    logic              unused_bits;

    assign idx      = bus.io_addr[ADDR_W-1:OFF_W];
    assign mem_idx  = idx[MEM_AW-1:0];
    assign in_range = (32'(idx) < DEPTH);
    assign rd_fire  = bus.io_en & ~bus.io_we;
    assign wr_fire  = bus.io_en & bus.io_we;
    assign cur_word = mem[mem_idx];
    assign rd_data  = in_range ? cur_word : '0;

    // Merge write data into the current word byte by byte.
    always_comb begin
        wr_word = cur_word;
        for (int k = 0; k < BE_W; k++) begin
            if (bus.io_be[k]) begin
                wr_word[8*k +: 8] = bus.io_data_write[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(INIT_BASE + i);
            end
        end else if (wr_fire && in_range) begin
            mem[mem_idx] <= wr_word;
        end
    end

    // Each stage tracks its own occupancy so S1 and S2 can hold different reads at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            st1 <= IDLE;
            st2 <= IDLE;
        end else begin
            st1 <= st1_next;
            st2 <= st2_next;
        end
    end

    always_comb begin
        st1_next = IDLE;
        st2_next = IDLE;
        if (rd_fire) begin
            st1_next = S1;
        end
        if (RD_LAT == 2 && st1 == S1) begin
            st2_next = S2;
        end
    end

    assign load_out = (RD_LAT == 1) ? rd_fire : (st1 == S1);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_data  <= '0;
            s1_err   <= 1'b0;
            out_data <= '0;
            out_err  <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            if (rd_fire) begin
                s1_data <= rd_data;
                s1_err  <= ~in_range;
            end
            if (load_out) begin
                out_data <= (RD_LAT == 1) ? rd_data : s1_data;
                out_err  <= (RD_LAT == 1) ? ~in_range : s1_err;
            end
            wr_err_q <= wr_fire & ~in_range;
        end
    end

    assign bus.io_rvalid    = (RD_LAT == 1) ? (st1 == S1) : (st2 == S2);
    assign bus.io_data_read = out_data;
    assign bus.io_err       = wr_err_q | (bus.io_rvalid & out_err);

`ifdef IO_PORT_BANK_TOHOST_EN
    logic              done_q;
    logic [DATA_W-1:0] code_q;

    // Only the first nonzero completion write is latched; the flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
            code_q <= '0;
        end else if (wr_fire && in_range && (32'(idx) == TOHOST_IDX) &&
                     (wr_word != '0) && !done_q) begin
            done_q <= 1'b1;
            code_q <= wr_word;
        end
    end

    assign bus.tohost_done = done_q;
    assign bus.tohost_code = code_q;
`else
    assign bus.tohost_done = 1'b0;
    assign bus.tohost_code = '0;
`endif

    assign unused_bits = ^{bus.io_addr, s1_data, s1_err, st2};
endmodule

// File: tb/tb_io_port_bank.sv
// tb/tb_io_port_bank.sv - directed self-checking bench for io_port_bank
module tb_io_port_bank;
    logic clk_tb = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk_tb = ~clk_tb;

    io_port_bank_if #(.DATA_W(32), .ADDR_W(10)) b1 ();
    io_port_bank_if #(.DATA_W(32), .ADDR_W(10)) b2 ();
    io_port_bank_if #(.DATA_W(32), .ADDR_W(10)) b3 ();

    io_port_bank u_dut1 (.clk(clk_tb), .reset(rst), .bus(b1));
    io_port_bank #(.RD_LAT(2)) u_dut2 (.clk(clk_tb), .reset(rst), .bus(b2));
    io_port_bank #(.DEPTH(64), .ADDR_W(10)) u_dut3 (.clk(clk_tb), .reset(rst), .bus(b3));

    task automatic cyc();
        @(posedge clk_tb);
        #1;
    endtask

    task automatic drv(input int which, input logic en, input logic we,
                       input logic [9:0] addr, input logic [3:0] be, input logic [31:0] d);
        case (which)
            1: begin b1.io_en = en; b1.io_we = we; b1.io_addr = addr; b1.io_be = be; b1.io_data_write = d; end
            2: begin b2.io_en = en; b2.io_we = we; b2.io_addr = addr; b2.io_be = be; b2.io_data_write = d; end
            default: begin b3.io_en = en; b3.io_we = we; b3.io_addr = addr; b3.io_be = be; b3.io_data_write = d; end
        endcase
    endtask

    task automatic idle_all();
        drv(1, 0, 0, 10'h0, 4'h0, 32'h0);
        drv(2, 0, 0, 10'h0, 4'h0, 32'h0);
        drv(3, 0, 0, 10'h0, 4'h0, 32'h0);
    endtask

    task automatic test_reset();
        checks++; if (b1.io_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got=%0b exp=0", b1.io_rvalid); end
        checks++; if (b1.io_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%0b exp=0", b1.io_err); end
        checks++; if (b1.io_data_read !== 32'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", b1.io_data_read); end
        checks++; if (b1.tohost_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%0b exp=0", b1.tohost_done); end
        checks++; if (b1.tohost_code !== 32'h0) begin errors++; $display("FAIL rst_code got=%h exp=0", b1.tohost_code); end
        checks++; if (b2.io_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid2 got=%0b exp=0", b2.io_rvalid); end
    endtask

    task automatic test_back_to_back();
        drv(1, 1, 0, 10'h000, 4'h0, 32'h0);
        cyc();
        checks++; if (b1.io_rvalid !== 1'b1 || b1.io_data_read !== 32'h1000) begin errors++; $display("FAIL b2b_w0 got=%0b/%h exp=1/00001000", b1.io_rvalid, b1.io_data_read); end
        drv(1, 1, 0, 10'h014, 4'h0, 32'h0);
        cyc();
        checks++; if (b1.io_rvalid !== 1'b1 || b1.io_data_read !== 32'h1005) begin errors++; $display("FAIL b2b_w5 got=%0b/%h exp=1/00001005", b1.io_rvalid, b1.io_data_read); end
        drv(1, 1, 0, 10'h3FC, 4'h0, 32'h0);
        cyc();
        checks++; if (b1.io_rvalid !== 1'b1 || b1.io_data_read !== 32'h10FF) begin errors++; $display("FAIL b2b_w255 got=%0b/%h exp=1/000010ff", b1.io_rvalid, b1.io_data_read); end
        drv(1, 0, 0, 10'h0, 4'h0, 32'h0);
        cyc();
        checks++; if (b1.io_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_end_rvalid got=%0b exp=0", b1.io_rvalid); end
        checks++; if (b1.io_data_read !== 32'h10FF) begin errors++; $display("FAIL b2b_hold got=%h exp=000010ff", b1.io_data_read); end
    endtask

    task automatic test_byte_enable();
        drv(1, 1, 1, 10'h00C, 4'b0101, 32'hAABBCCDD);
        cyc();
        checks++; if (b1.io_err !== 1'b0 || b1.io_rvalid !== 1'b0) begin errors++; $display("FAIL be_wr_resp got=%0b/%0b exp=0/0", b1.io_err, b1.io_rvalid); end
        drv(1, 1, 0, 10'h00C, 4'h0, 32'h0);
        cyc();
        checks++; if (b1.io_rvalid !== 1'b1 || b1.io_data_read !== 32'h00BB10DD) begin errors++; $display("FAIL be_read got=%0b/%h exp=1/00bb10dd", b1.io_rvalid, b1.io_data_read); end
        drv(1, 0, 0, 10'h0, 4'h0, 32'h0);
        cyc();
    endtask

    task automatic test_rd_lat2();
        drv(2, 1, 0, 10'h000, 4'h0, 32'h0);
        cyc();
        checks++; if (b2.io_rvalid !== 1'b0) begin errors++; $display("FAIL lat2_early got=%0b exp=0", b2.io_rvalid); end
        for (int i = 1; i < 5; i++) begin
            if (i < 4) drv(2, 1, 0, 10'(i * 4), 4'h0, 32'h0);
            else       drv(2, 0, 0, 10'h0, 4'h0, 32'h0);
            cyc();
            checks++; if (b2.io_rvalid !== 1'b1 || b2.io_data_read !== 32'(32'h1000 + i - 1)) begin errors++; $display("FAIL lat2_resp%0d got=%0b/%h exp=1/%h", i - 1, b2.io_rvalid, b2.io_data_read, 32'h1000 + i - 1); end
        end
        cyc();
        checks++; if (b2.io_rvalid !== 1'b0 || b2.io_data_read !== 32'h1003) begin errors++; $display("FAIL lat2_end got=%0b/%h exp=0/00001003", b2.io_rvalid, b2.io_data_read); end
    endtask

    task automatic test_out_of_range();
        drv(3, 1, 0, 10'h004, 4'h0, 32'h0);
        cyc();
        checks++; if (b3.io_rvalid !== 1'b1 || b3.io_err !== 1'b0 || b3.io_data_read !== 32'h1001) begin errors++; $display("FAIL oor_pre got=%0b/%0b/%h exp=1/0/00001001", b3.io_rvalid, b3.io_err, b3.io_data_read); end
        drv(3, 1, 0, 10'h200, 4'h0, 32'h0);
        cyc();
        checks++; if (b3.io_rvalid !== 1'b1 || b3.io_err !== 1'b1 || b3.io_data_read !== 32'h0) begin errors++; $display("FAIL oor_read got=%0b/%0b/%h exp=1/1/0", b3.io_rvalid, b3.io_err, b3.io_data_read); end
        drv(3, 1, 1, 10'h200, 4'hF, 32'hFFFFFFFF);
        cyc();
        checks++; if (b3.io_err !== 1'b1 || b3.io_rvalid !== 1'b0) begin errors++; $display("FAIL oor_write got=%0b/%0b exp=1/0", b3.io_err, b3.io_rvalid); end
        drv(3, 0, 0, 10'h0, 4'h0, 32'h0);
        cyc();
        checks++; if (b3.io_err !== 1'b0) begin errors++; $display("FAIL oor_err_pulse got=%0b exp=0", b3.io_err); end
        for (int i = 0; i < 64; i++) begin
            drv(3, 1, 0, 10'(i * 4), 4'h0, 32'h0);
            cyc();
            checks++; if (b3.io_rvalid !== 1'b1 || b3.io_data_read !== 32'(32'h1000 + i)) begin errors++; $display("FAIL oor_word%0d got=%0b/%h exp=1/%h", i, b3.io_rvalid, b3.io_data_read, 32'h1000 + i); end
        end
        drv(3, 0, 0, 10'h0, 4'h0, 32'h0);
        cyc();
    endtask

    task automatic test_tohost();
        logic        exp_done;
        logic [31:0] exp_code;
`ifdef IO_PORT_BANK_TOHOST_EN
        exp_done = 1'b1;
        exp_code = 32'h1;
`else
        exp_done = 1'b0;
        exp_code = 32'h0;
`endif
        checks++; if (b1.tohost_done !== 1'b0) begin errors++; $display("FAIL th_pre got=%0b exp=0", b1.tohost_done); end
        drv(1, 1, 1, 10'h3FC, 4'hF, 32'h1);
        cyc();
        checks++; if (b1.tohost_done !== exp_done || b1.tohost_code !== exp_code) begin errors++; $display("FAIL th_first got=%0b/%h exp=%0b/%h", b1.tohost_done, b1.tohost_code, exp_done, exp_code); end
        drv(1, 1, 1, 10'h3FC, 4'hF, 32'h3);
        cyc();
        checks++; if (b1.tohost_done !== exp_done || b1.tohost_code !== exp_code) begin errors++; $display("FAIL th_second got=%0b/%h exp=%0b/%h", b1.tohost_done, b1.tohost_code, exp_done, exp_code); end
        drv(1, 1, 0, 10'h3FC, 4'h0, 32'h0);
        cyc();
        checks++; if (b1.io_rvalid !== 1'b1 || b1.io_data_read !== 32'h3) begin errors++; $display("FAIL th_read got=%0b/%h exp=1/00000003", b1.io_rvalid, b1.io_data_read); end
        drv(1, 0, 0, 10'h0, 4'h0, 32'h0);
        cyc();
        checks++; if (b1.tohost_done !== exp_done) begin errors++; $display("FAIL th_sticky got=%0b exp=%0b", b1.tohost_done, exp_done); end
    endtask

    task automatic test_reset_flush();
        drv(2, 1, 0, 10'h000, 4'h0, 32'h0);
        cyc();
        rst = 1'b1;
        drv(2, 1, 1, 10'h000, 4'hF, 32'hDEADBEEF);
        cyc();
        checks++; if (b2.io_rvalid !== 1'b0) begin errors++; $display("FAIL flush_rst0 got=%0b exp=0", b2.io_rvalid); end
        drv(2, 1, 0, 10'h004, 4'h0, 32'h0);
        cyc();
        checks++; if (b2.io_rvalid !== 1'b0) begin errors++; $display("FAIL flush_rst1 got=%0b exp=0", b2.io_rvalid); end
        rst = 1'b0;
        drv(2, 0, 0, 10'h0, 4'h0, 32'h0);
        cyc();
        checks++; if (b2.io_rvalid !== 1'b0) begin errors++; $display("FAIL flush_post0 got=%0b exp=0", b2.io_rvalid); end
        cyc();
        checks++; if (b2.io_rvalid !== 1'b0 || b2.io_err !== 1'b0 || b2.io_data_read !== 32'h0 || b2.tohost_done !== 1'b0 || b2.tohost_code !== 32'h0) begin errors++; $display("FAIL flush_outs got=%0b/%0b/%h/%0b/%h exp=all 0", b2.io_rvalid, b2.io_err, b2.io_data_read, b2.tohost_done, b2.tohost_code); end
        checks++; if (b1.tohost_done !== 1'b0) begin errors++; $display("FAIL flush_done1 got=%0b exp=0", b1.tohost_done); end
        drv(2, 1, 0, 10'h000, 4'h0, 32'h0);
        cyc();
        drv(2, 0, 0, 10'h0, 4'h0, 32'h0);
        cyc();
        checks++; if (b2.io_rvalid !== 1'b1 || b2.io_data_read !== 32'h1000) begin errors++; $display("FAIL flush_word0 got=%0b/%h exp=1/00001000", b2.io_rvalid, b2.io_data_read); end
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        test_reset();
        test_back_to_back();
        test_byte_enable();
        test_rd_lat2();
        test_out_of_range();
        test_tohost();
        test_reset_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
